// File: rtl/seq_sort_pkg.sv
// seq_sort shared types: FSM states, default sizes, width helpers.
// Build option SEQ_SORT_DESCEND_EN is handled in seq_sort_cmp_swap.sv.
package seq_sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int W_DEF = 6;
  localparam int N_DEF = 8;

  function automatic int idx_width(
    input int n
  );
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int pc_width(
    input int n
  );
    return idx_width(n) + 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(N_DEF);
  localparam int PC_W_DEF  = pc_width(N_DEF);

endpackage

// File: rtl/seq_sort_if.sv
// seq_sort stream bundle: load side, drain side and busy flag.
// master drives words in and accepts sorted words; slave is the sorter.
interface seq_sort_if
  import seq_sort_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output busy
  );

endinterface

// File: rtl/seq_sort_cmp_swap.sv
// Compare-swap cell; ties pass straight through. Defining
// SEQ_SORT_DESCEND_EN puts the larger word on the lower index.
module cmp_swap #(
  parameter int W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic swap;

`ifdef SEQ_SORT_DESCEND_EN
  assign swap = (b > a);
`else
  assign swap = (b < a);
`endif

  assign lo = swap ? b : a;
  assign hi = swap ? a : b;

endmodule

// File: rtl/seq_sort.sv
// N-word streaming sorter: load, odd-even transposition, drain.
// Order set by SEQ_SORT_DESCEND_EN inside cmp_swap (default ascending).
module seq_sort
  import seq_sort_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input logic       clk,
  input logic       rst,
  seq_sort_if.slave bus
);

  localparam int IW = idx_width(N);
  localparam int PW = pc_width(N);

  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [PW-1:0] PC_END   = PW'(N);

  state_t state;
  state_t state_n;

  logic [IW-1:0]        idx;
  logic [PW-1:0]        pc;
  logic                 live;
  logic [N-1:0][W-1:0]  mem;
  logic [N-1:0][W-1:0]  ev;
  logic [N-1:0][W-1:0]  od;

  logic acc;
  logic hs;
  logic at_last;
  logic in_load;
  logic in_sort;
  logic in_drain;

  assign in_load  = (state == LOAD);
  assign in_sort  = (state == SORT);
  assign in_drain = (state == DRAIN);
  assign at_last  = (idx == IDX_LAST);

  // live gates in_ready so it stays low through every reset cycle
  assign bus.in_ready  = live && in_load;
  assign bus.out_valid = in_drain;
  assign bus.out_last  = in_drain && at_last;
  assign bus.out_data  = in_drain ? mem[idx] : '0;
  assign bus.busy      = in_sort || in_drain;

  assign acc = bus.in_valid && bus.in_ready;
  assign hs  = bus.out_valid && bus.out_ready;

  for (genvar i = 0; i < N / 2; i++) begin : g_even
    cmp_swap #(
      .W (W)
    ) u_cs (
      .a  (mem[2*i]),
      .b  (mem[2*i+1]),
      .lo (ev[2*i]),
      .hi (ev[2*i+1])
    );
  end

  assign od[0]   = mem[0];
  assign od[N-1] = mem[N-1];

  for (genvar i = 0; i < N / 2 - 1; i++) begin : g_odd
    cmp_swap #(
      .W (W)
    ) u_cs (
      .a  (mem[2*i+1]),
      .b  (mem[2*i+2]),
      .lo (od[2*i+1]),
      .hi (od[2*i+2])
    );
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      in_load: begin
        if (acc && at_last) state_n = SORT;
      end
      in_sort: begin
        if (pc == PC_END) state_n = DRAIN;
      end
      in_drain: begin
        if (hs && at_last) state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= LOAD;
      live  <= 1'b0;
    end else begin
      state <= state_n;
      live  <= 1'b1;
    end
  end

  // pc counts N passes, then one extra cycle at PC_END hands off to DRAIN
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx <= '0;
      pc  <= '0;
      mem <= '0;
    end else begin
      unique case (1'b1)
        in_load: begin
          if (acc) begin
            mem[idx] <= bus.in_data;
            if (at_last) begin
              idx <= '0;
              pc  <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        in_sort: begin
          if (pc != PC_END) begin
            mem <= pc[0] ? od : ev;
            pc  <= pc + 1'b1;
          end
        end
        in_drain: begin
          if (hs) begin
            idx <= at_last ? '0 : idx + 1'b1;
          end
        end
        default: begin
          idx <= '0;
          pc  <= '0;
        end
      endcase
    end
  end

endmodule
